// File: rtl/regfile_bypass_sb.sv
// Register file with byte-lane writes, write-through bypass and a pending-write scoreboard.
// Define REGFILE_RDREG_EN to register the read data outputs (one cycle after the address).
module regfile_bypass_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [ADDR_W-1:0]   i_rd_addr_a,
    input  logic [ADDR_W-1:0]   i_rd_addr_b,
    output logic [DATA_W-1:0]   o_rd_data_a,
    output logic [DATA_W-1:0]   o_rd_data_b,
    output logic                o_busy_a,
    output logic                o_busy_b,
    input  logic                i_wr_en,
    input  logic [ADDR_W-1:0]   i_wr_addr,
    input  logic [DATA_W/8-1:0] i_wr_be,
    input  logic [DATA_W-1:0]   i_wr_data,
    input  logic                i_sb_set,
    input  logic [ADDR_W-1:0]   i_sb_set_addr,
    output logic                o_sb_dup_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_sb;
    logic              r_dup_err;

    logic              w_wr_ok;
    logic              w_set_ok;
    logic              w_dup;
    logic [DATA_W-1:0] w_be_mask;
    logic [DATA_W-1:0] w_wr_merged;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    assign w_wr_ok  = i_wr_en  && !((ZERO_REG != 0) && (i_wr_addr == '0));
    assign w_set_ok = i_sb_set && !((ZERO_REG != 0) && (i_sb_set_addr == '0));

    // A set on an already pending register is only legal when that register retires this cycle.
    assign w_dup = w_set_ok && r_sb[i_sb_set_addr] && !(w_wr_ok && (i_wr_addr == i_sb_set_addr));

    // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_be_mask = '0;
        for (int i = 0; i < NB; i++) begin
            w_be_mask[8*i +: 8] = {8{i_wr_be[i]}};
        end
    end

    assign w_wr_merged = (r_mem[i_wr_addr] & ~w_be_mask) | (i_wr_data & w_be_mask);

    always_comb begin
        w_rd_a = r_mem[i_rd_addr_a];
        w_rd_b = r_mem[i_rd_addr_b];
        if (w_wr_ok && (i_wr_addr == i_rd_addr_a)) w_rd_a = w_wr_merged;
        if (w_wr_ok && (i_wr_addr == i_rd_addr_b)) w_rd_b = w_wr_merged;
        if ((ZERO_REG != 0) && (i_rd_addr_a == '0)) w_rd_a = '0;
        if ((ZERO_REG != 0) && (i_rd_addr_b == '0)) w_rd_b = '0;
    end

    assign o_busy_a = r_sb[i_rd_addr_a] && !(w_wr_ok && (i_wr_addr == i_rd_addr_a));
    assign o_busy_b = r_sb[i_rd_addr_b] && !(w_wr_ok && (i_wr_addr == i_rd_addr_b));

    // NOTE: the array is cleared on reset because software relies on all registers reading zero
    // afterwards; this rules out a plain RAM macro for r_mem.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_sb      <= '0;
            r_dup_err <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_mem[i_wr_addr] <= w_wr_merged;
                r_sb[i_wr_addr]  <= 1'b0;
            end
            // NOTE: non-blocking assignments; the later set overrides the clear above on the
            // same address, so a new producer issued as the old one retires stays pending.
            if (w_set_ok) r_sb[i_sb_set_addr] <= 1'b1;
            if (w_dup)    r_dup_err <= 1'b1;
        end
    end

    assign o_sb_dup_err = r_dup_err;

`ifdef REGFILE_RDREG_EN
    logic [DATA_W-1:0] r_rd_a;
    logic [DATA_W-1:0] r_rd_b;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_a <= '0;
            r_rd_b <= '0;
        end else begin
            r_rd_a <= w_rd_a;
            r_rd_b <= w_rd_b;
        end
    end

    assign o_rd_data_a = r_rd_a;
    assign o_rd_data_b = r_rd_b;
`else
    assign o_rd_data_a = w_rd_a;
    assign o_rd_data_b = w_rd_b;
`endif

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed self-checking bench for regfile_bypass_sb (default parameters, either read build).
module tb_regfile_bypass_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        busy_a, busy_b;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        sb_set;
    logic [4:0]  sb_set_addr;
    logic        sb_dup_err;

    int tests = 0;
    int fails = 0;

    regfile_bypass_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_rd_addr_a   (rd_addr_a),
        .i_rd_addr_b   (rd_addr_b),
        .o_rd_data_a   (rd_data_a),
        .o_rd_data_b   (rd_data_b),
        .o_busy_a      (busy_a),
        .o_busy_b      (busy_b),
        .i_wr_en       (wr_en),
        .i_wr_addr     (wr_addr),
        .i_wr_be       (wr_be),
        .i_wr_data     (wr_data),
        .i_sb_set      (sb_set),
        .i_sb_set_addr (sb_set_addr),
        .o_sb_dup_err  (sb_dup_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; checks happen 1 unit after that.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait until read data for the currently presented addresses is valid.
    task automatic sample();
`ifdef REGFILE_RDREG_EN
        tick();
`else
        #1;
`endif
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
        sb_set = 1'b0; sb_set_addr = '0; rd_addr_a = '0; rd_addr_b = '0;
        tick(); tick();
        rst = 1'b0;

        // 1: everything reads zero after reset
        for (int a = 0; a < 32; a++) begin
            rd_addr_a = 5'(a);
            rd_addr_b = 5'(31 - a);
            sample();
            check($sformatf("rst_rd_a[%0d]", a), rd_data_a, 32'h0);
            check($sformatf("rst_rd_b[%0d]", 31 - a), rd_data_b, 32'h0);
            check($sformatf("rst_busy_a[%0d]", a), busy_a, 1'b0);
            check($sformatf("rst_busy_b[%0d]", 31 - a), busy_b, 1'b0);
        end
        check("rst_dup_err", sb_dup_err, 1'b0);

        // 2: partial write and bypass on both ports
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hAABBCCDD; wr_be = 4'b1111;
        tick();
        wr_data = 32'h11223344; wr_be = 4'b0101;
        rd_addr_a = 5'd5; rd_addr_b = 5'd5;
        sample();
        check("bypass_a_5", rd_data_a, 32'hAA22CC44);
        check("bypass_b_5", rd_data_b, 32'hAA22CC44);
        tick();
        wr_en = 1'b0;
        sample();
        check("stored_a_5", rd_data_a, 32'hAA22CC44);
        check("stored_b_5", rd_data_b, 32'hAA22CC44);

        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h5A5A5A5A; wr_be = 4'b1000;
        tick();
        wr_en = 1'b0; rd_addr_a = 5'd6;
        sample();
        check("lane3_only_6", rd_data_a, 32'h5A000000);

        // 3: register 0 is hardwired
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; wr_be = 4'b1111;
        rd_addr_a = 5'd0;
        sample();
        check("zero_during_wr", rd_data_a, 32'h0);
        tick();
        wr_en = 1'b0;
        sample();
        check("zero_after_wr", rd_data_a, 32'h0);
        sb_set = 1'b1; sb_set_addr = 5'd0;
        tick(); tick();
        sb_set = 1'b0;
        #1;
        check("zero_busy", busy_a, 1'b0);
        check("zero_no_dup", sb_dup_err, 1'b0);

        // 4: scoreboard set, retire with empty byte enables, set+clear race
        sb_set = 1'b1; sb_set_addr = 5'd7; rd_addr_a = 5'd7; rd_addr_b = 5'd7;
        #1;
        check("busy_not_same_cycle", busy_a, 1'b0);
        tick();
        sb_set = 1'b0;
        #1;
        check("busy_a_7", busy_a, 1'b1);
        check("busy_b_7", busy_b, 1'b1);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF; wr_be = 4'b0000;
        #1;
        check("busy_forced_0", busy_a, 1'b0);
        tick();
        wr_en = 1'b0;
        #1;
        check("busy_retired_7", busy_a, 1'b0);
        sample();
        check("be0_no_data_7", rd_data_a, 32'h0);

        sb_set = 1'b1; sb_set_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00000099; wr_be = 4'b1111;
        rd_addr_b = 5'd9;
        tick();
        sb_set = 1'b0; wr_en = 1'b0;
        #1;
        check("set_wins_9", busy_b, 1'b1);
        check("set_wins_no_dup", sb_dup_err, 1'b0);
        sb_set = 1'b1; wr_en = 1'b1; wr_be = 4'b0000;
        tick();
        sb_set = 1'b0; wr_en = 1'b0;
        #1;
        check("reissue_busy_9", busy_b, 1'b1);
        check("reissue_no_dup", sb_dup_err, 1'b0);
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        #1;
        check("retire_9", busy_b, 1'b0);

        // 5: duplicate issue is sticky until reset
        sb_set = 1'b1; sb_set_addr = 5'd3; rd_addr_a = 5'd3;
        tick();
        #1;
        check("dup_first_set", sb_dup_err, 1'b0);
        tick();
        sb_set = 1'b0;
        #1;
        check("dup_second_set", sb_dup_err, 1'b1);
        check("dup_bit_kept", busy_a, 1'b1);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33; wr_be = 4'b1111;
        tick();
        wr_en = 1'b0;
        #1;
        check("dup_sticky", sb_dup_err, 1'b1);
        check("dup_retired_3", busy_a, 1'b0);

        // 6: reset beats same-cycle write and scoreboard set
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h12345678; wr_be = 4'b1111;
        sb_set = 1'b1; sb_set_addr = 5'd4;
        tick();
        rst = 1'b0; wr_en = 1'b0; sb_set = 1'b0;
        rd_addr_a = 5'd4; rd_addr_b = 5'd5;
        sample();
        check("rstprio_rd_4", rd_data_a, 32'h0);
        check("rstprio_busy_4", busy_a, 1'b0);
        check("rst_cleared_5", rd_data_b, 32'h0);
        check("rst_clears_dup", sb_dup_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
